accum_drain: RTL and testbench

//  Read-side controller for the bank of SYS_ARR_COLS accumulator columns. After the systolic array

---
 rtl/accum_pkg.sv | 7 +
 rtl/accum_drain_fifo.sv | 22 ++
 rtl/accum_drain.sv | 87 ++++++++
 tb/tb_accum_drain.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// accum_pkg: shared sizing helper and drain FSM state encoding for the accumulator bank
package accum_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, FIN} state_t;
  function automatic int num_accum_rows(input int max_rows, input int max_cols, input int arr_cols);
    return max_rows * (max_cols / arr_cols);
  endfunction
endpackage

// File: rtl/accum_drain_fifo.sv
// accum_drain_fifo: 2-deep shift FIFO with combinational head for packed row words
module accum_drain_fifo #(
  parameter int WIDTH = 257
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] e0, e1;
  assign head = e0;
  // e0 is always the head; e1 only holds the second word when two are queued
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else count <= count + 2'(push) - 2'(pop);
    if (pop || count == 2'd0) e0 <= (count == 2'd2) ? e1 : din;
    if (push && count == (pop ? 2'd2 : 2'd1)) e1 <= din;
  end
endmodule

// File: rtl/accum_drain.sv
// accum_drain: walks a row range of the accumulator columns and streams packed rows out
module accum_drain
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int SYS_ARR_COLS = 16,
  localparam int NUM_ACCUM_ROWS = num_accum_rows(MAX_OUT_ROWS, MAX_OUT_COLS, SYS_ARR_COLS),
  localparam int AW = $clog2(NUM_ACCUM_ROWS),
  localparam int DW = SYS_ARR_COLS * DATA_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   num_rows,
  input  logic          clear_after,
  output logic          acc_rd_en,
  output logic [AW-1:0] acc_rd_addr,
  output logic          acc_clear,
  input  logic [DW-1:0] acc_rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);
  state_t state, state_nx;
  logic [AW-1:0] base;
  logic [AW:0] nrows, row_cnt, sum;
  logic clr, inflight, inflight_last, pop, issue;
  logic [1:0] fifo_count;
  logic [DW:0] head;
  assign pop = out_valid & out_ready;
  assign issue = state == DRAIN && row_cnt < nrows &&
                 ({1'b0, fifo_count} + {2'b0, inflight}) < 3'd2 + {2'b0, pop};
  assign sum = {1'b0, base} + row_cnt;
  assign acc_rd_addr = AW'(sum >= (AW+1)'(NUM_ACCUM_ROWS) ? sum - (AW+1)'(NUM_ACCUM_ROWS) : sum);
  assign acc_rd_en = issue;
  assign acc_clear = state == CLEAR;
  assign busy = state != IDLE;
  assign done = state == FIN;
  // a word returning from the columns is presented directly when the FIFO is empty,
  // which gives out_valid the cycle after rd_en; it is only queued if not taken
  assign out_valid = |fifo_count | inflight;
  assign {out_last, out_data} = |fifo_count ? head : {inflight_last, acc_rd_data};
  accum_drain_fifo #(.WIDTH(DW + 1)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(inflight & ~(fifo_count == 2'd0 & out_ready)),
    .pop(out_ready & |fifo_count),
    .din({inflight_last, acc_rd_data}),
    .head(head),
    .count(fifo_count)
  );
  // next-state: drain ends on the accepted last word, optional one-cycle clear, then done
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE)  ? (start ? ((num_rows != '0) ? DRAIN : (clear_after ? CLEAR : FIN)) : IDLE) :
               (state == DRAIN) ? ((pop && out_last) ? (clr ? CLEAR : FIN) : DRAIN) :
               (state == CLEAR) ? FIN : IDLE;
  end
  // state register, command capture, row counter and in-flight read tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
      row_cnt <= '0;
      base <= '0;
      nrows <= '0;
      clr <= 1'b0;
    end else begin
      state <= state_nx;
      inflight <= issue;
      inflight_last <= issue && row_cnt == nrows - (AW+1)'(1);
      if (state == IDLE && start) begin
        base <= base_addr;
        nrows <= num_rows;
        clr <= clear_after;
        row_cnt <= '0;
      end else if (issue) row_cnt <= row_cnt + (AW+1)'(1);
    end
  end
endmodule

// File: tb/tb_accum_drain.sv
// tb_accum_drain: randomized drains against a row-list model of the column bank
module tb_accum_drain;
  localparam int N = 1024;
  localparam int AW = 10;
  localparam int W = 256;
  logic clk = 0, reset = 1, start = 0, clear_after = 0, out_ready = 0, fill = 0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] num_rows = '0;
  logic acc_rd_en, acc_clear, out_valid, out_last, busy, done;
  logic [AW-1:0] acc_rd_addr;
  logic [W-1:0] acc_rd_data = '0, out_data;
  logic [W-1:0] mem [N];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  accum_drain dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .clear_after(clear_after), .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr),
    .acc_clear(acc_clear), .acc_rd_data(acc_rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );
  // column bank: one-cycle read latency, clear wipes every entry
  always @(posedge clk) begin
    if (acc_rd_en) acc_rd_data <= mem[acc_rd_addr];
    if (fill) begin
      for (int i = 0; i < N; i++)
        for (int c = 0; c < W / 32; c++) mem[i][c*32 +: 32] = $urandom;
    end else if (acc_clear) begin
      for (int i = 0; i < N; i++) mem[i] = '0;
    end
  end
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic refill;
    fill = 1;
    step();
    fill = 0;
  endtask
  function automatic logic ready_at(input int mode, input int cyc);
    logic [4:0] pat;
    pat = 5'b01001;
    return mode == 0 ? 1'b1 : mode == 1 ? pat[(cyc - 1) % 5] : 1'($urandom_range(0, 1));
  endfunction
  task automatic run_drain(input int b, input int n, input bit clr, input int mode, input int poke_cyc);
    logic [W-1:0] expq[$];
    logic [W-1:0] held;
    logic held_last, p;
    int issued, acc, cyc, clr_cnt, done_cnt, done_cyc, last_hs, clr_cyc;
    bit stalled;
    issued = 0; acc = 0; clr_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs = -1; clr_cyc = -1;
    stalled = 0; held = '0; held_last = 0;
    for (int r = 0; r < n; r++) expq.push_back(mem[(b + r) % N]);
    base_addr = AW'(b); num_rows = (AW+1)'(n); clear_after = clr; start = 1;
    step();
    cyc = 1;
    while (done_cnt == 0 && cyc < 300) begin
      start = 0;
      out_ready = ready_at(mode, cyc);
      #1;
      p = out_valid & out_ready;
      chk("busy", busy, 1);
      if (acc_clear) begin
        clr_cnt++; clr_cyc = cyc;
        chk("clr_quiet", acc_rd_en | out_valid | (issued != acc), 0);
      end
      if (acc_rd_en) begin
        chk("rd_addr", acc_rd_addr, (b + issued) % N);
        chk("rd_room", (issued - acc - int'(p)) < 2, 1);
        chk("rd_left", issued < n, 1);
        if (mode == 0) chk("rd_cyc", cyc, 1 + issued);
        issued++;
      end
      if (out_valid) begin
        if (stalled) begin
          chk("hold_data", out_data, held);
          chk("hold_last", out_last, held_last);
        end
        if (out_ready) begin
          chk("extra_row", acc < n, 1);
          if (acc < n) chk("data", out_data, expq[acc]);
          chk("last", out_last, acc == n - 1);
          if (mode == 0) chk("out_cyc", cyc, 2 + acc);
          acc++; last_hs = cyc;
        end
      end
      stalled = out_valid & ~out_ready;
      held = out_data; held_last = out_last;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (cyc == poke_cyc) begin
        start = 1; base_addr = AW'($urandom); num_rows = (AW+1)'(5); clear_after = 1;
      end
      step();
      cyc++;
    end
    start = 0;
    chk("done_seen", done_cnt, 1);
    chk("accepted", acc, n);
    chk("issued", issued, n);
    chk("clear_cnt", clr_cnt, clr);
    if (clr) chk("clr_cyc", clr_cyc, n > 0 ? last_hs + 1 : 1);
    chk("done_cyc", done_cyc, (n > 0 ? last_hs + 1 : 1) + int'(clr));
    for (int k = 0; k < 3; k++) begin
      chk("idle_busy", busy, 0);
      chk("idle_rd", acc_rd_en, 0);
      chk("idle_valid", out_valid, 0);
      chk("idle_done", done, 0);
      chk("idle_clear", acc_clear, 0);
      step();
    end
  endtask
  initial begin
    fill = 1;
    step();
    fill = 0;
    step();
    chk("rst_rd", acc_rd_en, 0);
    chk("rst_clear", acc_clear, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 0;
    step();
    run_drain(0, 4, 0, 0, -1);
    run_drain(N - 2, 4, 0, 0, -1);
    run_drain(int'($urandom_range(0, N - 1)), 8, 0, 1, 3);
    run_drain(100, 3, 1, 0, -1);
    chk("cleared_row", mem[101], '0);
    run_drain(100, 3, 0, 0, -1);
    refill();
    run_drain(7, 0, 0, 0, 1);
    run_drain(9, 0, 1, 0, -1);
    refill();
    base_addr = 50; num_rows = 8; clear_after = 1; out_ready = 0; start = 1;
    step();
    start = 0;
    repeat (5) step();
    chk("full_valid", out_valid, 1);
    chk("full_busy", busy, 1);
    reset = 1;
    step();
    reset = 0;
    chk("abort_rd", acc_rd_en, 0);
    chk("abort_clear", acc_clear, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_last", out_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("abort_noclr", acc_clear, 0);
      chk("abort_nodone", done, 0);
    end
    run_drain(int'($urandom_range(0, N - 1)), 5, 0, 2, -1);
    for (int t = 0; t < 8; t++) begin
      automatic bit c = 1'($urandom_range(0, 1));
      run_drain(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 9)), c, 2, -1);
      if (c) refill();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
